regfile_dump: RTL and testbench
===============================

Name: regfile_dump

Overview:
- Debug/verification reader for the CPU's 32x32 register file.
- On a start request, walks the register index range [range_lo..range_hi] on a dedicated read-address port. Each 32-bit value is emitted as one beat on a valid/ready stream tagged with its index.
- Sits beside the register file on a spare combinational read port, for trace dumps at test end or on a breakpoint.
- Never writes the register file.

Parameters:
- DATA_W, 32, register width / out_data width.
- IDX_W, 5, register index width (32 registers).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a dump; sampled in IDLE only.
- range_lo  in  IDX_W  first index; sampled with start.
- range_hi  in  IDX_W  last index, inclusive; sampled with start.
- rf_addr  out  IDX_W  read address to register file read port.
- rf_data  in  DATA_W  combinational read data for rf_addr.
- out_valid  out  1  beat valid.
- out_ready  in  1  sink accepts beat.
- out_data  out  DATA_W  register value or checksum.
- out_idx  out  IDX_W  index of the register in out_data.
- out_last  out  1  final beat of the dump.
- out_chk  out  1  beat carries checksum (only with the optional feature; otherwise 0).
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse at the end of the dump.
- err  out  1  sticky range error; cleared by next accepted start.

Behaviour:
- Reset values (async, rst_n=0): state=IDLE, ptr=0, rf_addr=0, out_valid=0, out_data=0, out_idx=0, out_last=0, out_chk=0, busy=0, done=0, err=0.
- Reset mid-dump aborts immediately. No further beats are issued and done is not pulsed.
- rf_addr always equals the internal pointer ptr, and is registered.
- IDLE:
  - start=1 and range_lo<=range_hi: ptr<=range_lo, hi<=range_hi, err<=0, go to LOAD.
  - start=1 and range_lo>range_hi: err<=1, go to DONE. No beats are emitted.
- LOAD (1 cycle): capture out_data<=rf_data, out_idx<=ptr, out_last<=(ptr==hi), out_valid<=1, go to SEND.
- SEND:
  - Hold out_valid, out_data, out_idx and out_last stable while out_ready=0.
  - On out_valid&&out_ready: out_valid<=0.
  - If out_last, go to DONE; else ptr<=ptr+1 and go to LOAD.
- DONE (1 cycle): done=1, busy=0 next, go to IDLE.
- Timing:
  - Throughput: 1 beat per 2 cycles with out_ready tied high.
  - First out_valid appears 2 cycles after start.
  - Full dump of 0..31: done is high in cycle 2*32+1 after start, with no backpressure.
- start while busy: ignored, no effect.
- ptr never wraps. range_hi=31 terminates by the ptr==hi compare, not by overflow.
- Data is sampled in LOAD. A regfile write to an index after its LOAD is not reflected in that beat.
- Register 0 is dumped like any other index; the regfile returns 0 for it.

Optional Feature:
- Macro: REGDUMP_CHECKSUM_EN.
- When defined:
  - A DATA_W XOR accumulator is cleared on an accepted start and XORed with each captured value in LOAD.
  - The last register beat has out_last=0.
  - After it is accepted, state CHK (1 cycle) loads out_data=accumulator, out_idx=hi, out_chk=1, out_last=1, out_valid=1, then goes to SEND.
  - The range-error path emits no checksum beat.
- When not defined: no accumulator, no CHK state, out_chk tied 0.

Test Plan:
- Regfile preloaded reg[i]=i*0x01010101; start with lo=0, hi=31, out_ready=1 -> 32 beats, out_idx 0..31, beat 5 data=0x05050505, out_last only on idx 31, done pulse 65 cycles after start.
- lo=hi=7, reg[7]=0xDEADBEEF -> exactly one beat {idx 7, data 0xDEADBEEF, last=1}, then done.
- lo=10, hi=12, out_ready low for 4 cycles on each beat -> out_data/out_idx held stable while stalled; beats 10,11,12 in order; no loss or duplication.
- lo=20, hi=3 -> no out_valid, err=1, done pulses; next start lo=0, hi=0 clears err.
- start pulsed again mid-dump, and rst_n asserted during SEND of idx 4 -> second start ignored; on reset, all outputs return to reset values at once and no done pulse occurs.
- REGDUMP_CHECKSUM_EN, lo=1, hi=2, reg1=0xF0F0F0F0, reg2=0x0F0F00FF -> third beat out_chk=1, data=0xFFFFF00F, last=1.

Source files
------------

// File: rtl/regfile_dump.sv
// Walks register indices [range_lo..range_hi] on a spare read port and streams each value, tagged with its index.
// Latency: first beat 2 cycles after start, then 1 beat per 2 cycles; done pulses 1 cycle after the last beat is accepted.
// Backpressure: beats hold stable while out_ready=0. REGDUMP_CHECKSUM_EN appends an XOR checksum beat.
module regfile_dump #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [IDX_W-1:0]  range_lo,
    input  logic [IDX_W-1:0]  range_hi,
    output logic [IDX_W-1:0]  rf_addr,
    input  logic [DATA_W-1:0] rf_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [IDX_W-1:0]  out_idx,
    output logic              out_last,
    output logic              out_chk,
    output logic              busy,
    output logic              done,
    output logic              err
);

`ifdef REGDUMP_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, LOAD, SEND, DONE, CHK} state_t;
`else
    typedef enum logic [2:0] {IDLE, LOAD, SEND, DONE} state_t;
`endif

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   ptr, ptr_nxt;
    logic [IDX_W-1:0]   hi, hi_nxt;
    logic [DATA_W-1:0]  data_nxt;
    logic [IDX_W-1:0]   idx_nxt;
    logic               valid_nxt, last_nxt, err_nxt;
`ifdef REGDUMP_CHECKSUM_EN
    logic [DATA_W-1:0]  acc, acc_nxt;
    logic               chk_q, chk_nxt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            hi        <= '0;
            out_data  <= '0;
            out_idx   <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            err       <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
            acc       <= '0;
            chk_q     <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            hi        <= hi_nxt;
            out_data  <= data_nxt;
            out_idx   <= idx_nxt;
            out_valid <= valid_nxt;
            out_last  <= last_nxt;
            err       <= err_nxt;
`ifdef REGDUMP_CHECKSUM_EN
            acc       <= acc_nxt;
            chk_q     <= chk_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        hi_nxt    = hi;
        data_nxt  = out_data;
        idx_nxt   = out_idx;
        valid_nxt = out_valid;
        last_nxt  = out_last;
        err_nxt   = err;
`ifdef REGDUMP_CHECKSUM_EN
        acc_nxt   = acc;
        chk_nxt   = chk_q;
`endif
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (range_lo <= range_hi) begin
                        ptr_nxt   = range_lo;
                        hi_nxt    = range_hi;
                        err_nxt   = 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
                        acc_nxt   = '0;
`endif
                        state_nxt = LOAD;
                    end else begin
                        err_nxt   = 1'b1;
                        state_nxt = DONE;
                    end
                end
            end
            LOAD: begin
                data_nxt  = rf_data;
                idx_nxt   = ptr;
                valid_nxt = 1'b1;
`ifdef REGDUMP_CHECKSUM_EN
                // The checksum beat carries the last flag instead.
                last_nxt  = 1'b0;
                acc_nxt   = acc ^ rf_data;
`else
                last_nxt  = (ptr == hi);
`endif
                state_nxt = SEND;
            end
            SEND: begin
                if (out_ready) begin
                    valid_nxt = 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
                    chk_nxt   = 1'b0;
`endif
                    if (out_last) begin
                        state_nxt = DONE;
`ifdef REGDUMP_CHECKSUM_EN
                    end else if (ptr == hi) begin
                        state_nxt = CHK;
`endif
                    end else begin
                        ptr_nxt   = ptr + IDX_W'(1);
                        state_nxt = LOAD;
                    end
                end
            end
            DONE: state_nxt = IDLE;
`ifdef REGDUMP_CHECKSUM_EN
            CHK: begin
                data_nxt  = acc;
                idx_nxt   = hi;
                chk_nxt   = 1'b1;
                last_nxt  = 1'b1;
                valid_nxt = 1'b1;
                state_nxt = SEND;
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    assign rf_addr = ptr;
    assign busy    = (state != IDLE) && (state != DONE);
    assign done    = (state == DONE);
`ifdef REGDUMP_CHECKSUM_EN
    assign out_chk = chk_q;
`else
    assign out_chk = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_dump.sv
// Randomized bench for regfile_dump: a behavioural regfile plus a beat-list reference model per dump.
module tb_regfile_dump;

    logic        clk = 1'b0;
    logic        rst_n, start, out_ready;
    logic [4:0]  range_lo, range_hi, rf_addr, out_idx;
    logic [31:0] rf_data, out_data;
    logic        out_valid, out_last, out_chk, busy, done, err;
    logic [31:0] rf [32];
    int          total = 0;
    int          bad   = 0;

`ifdef REGDUMP_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    typedef struct {
        int          idx;
        logic [31:0] data;
        bit          last;
        bit          chk;
    } beat_t;
    beat_t exp_q[$];

    always #5 clk = ~clk;
    assign rf_data = rf[rf_addr];

    regfile_dump #(.DATA_W(32), .IDX_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .range_lo(range_lo), .range_hi(range_hi),
        .rf_addr(rf_addr), .rf_data(rf_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_idx(out_idx), .out_last(out_last), .out_chk(out_chk),
        .busy(busy), .done(done), .err(err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Expected beat list: every index in range with its value at start, then optional XOR beat.
    function automatic void build_model(input int lo, input int hi);
        logic [31:0] x = '0;
        exp_q.delete();
        if (lo > hi) return;
        for (int i = lo; i <= hi; i++) begin
            exp_q.push_back('{i, rf[i], (i == hi) && !CHK_EN, 1'b0});
            x ^= rf[i];
        end
        if (CHK_EN) exp_q.push_back('{hi, x, 1'b1, 1'b1});
    endfunction

    task automatic check_reset_vals(input string pfx);
        check({pfx, "_rf_addr"}, 32'(rf_addr), 0);
        check({pfx, "_valid"}, 32'(out_valid), 0);
        check({pfx, "_data"}, out_data, 0);
        check({pfx, "_idx"}, 32'(out_idx), 0);
        check({pfx, "_last"}, 32'(out_last), 0);
        check({pfx, "_chk"}, 32'(out_chk), 0);
        check({pfx, "_busy"}, 32'(busy), 0);
        check({pfx, "_done"}, 32'(done), 0);
        check({pfx, "_err"}, 32'(err), 0);
    endtask

    // mode: 0 ready high, 1 four stall cycles per beat, 2 random ready.
    task automatic run_dump(input int lo, input int hi, input int mode, input int abort_idx, input bit restart);
        int          n = 0;
        int          stall = 0;
        int          seen = 0;
        int          nbeats;
        bit          held = 0;
        bit          fin = 0;
        beat_t       e;
        logic [31:0] hd;
        logic [4:0]  hx;
        logic        hl, hc;
        build_model(lo, hi);
        nbeats = exp_q.size();
        @(negedge clk);
        start = 1'b1; range_lo = lo[4:0]; range_hi = hi[4:0]; out_ready = 1'b0;
        while (!fin) begin
            @(negedge clk);
            n++;
            start = 1'b0;
            if (restart && n == 3) begin
                start = 1'b1; range_lo = 5'd20; range_hi = 5'd25;
            end
            if (n == 1 && lo <= hi) check("busy_after_start", 32'(busy), 1);
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (stall >= 4);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (out_valid) begin
                if (int'(out_idx) == abort_idx && !out_chk) begin
                    rst_n = 1'b0;
                    #1;
                    check_reset_vals("abort");
                    repeat (3) begin
                        @(negedge clk);
                        check("abort_no_done", 32'(done), 0);
                    end
                    rst_n = 1'b1;
                    start = 1'b0; out_ready = 1'b0;
                    repeat (3) begin
                        @(negedge clk);
                        check("post_abort_done", 32'(done), 0);
                        check("post_abort_valid", 32'(out_valid), 0);
                    end
                    exp_q.delete();
                    return;
                end
                if (held) begin
                    check("hold_data", out_data, hd);
                    check("hold_idx", 32'(out_idx), 32'(hx));
                    check("hold_last", 32'(out_last), 32'(hl));
                    check("hold_chk", 32'(out_chk), 32'(hc));
                end
                if (out_ready) begin
                    seen++;
                    if (exp_q.size() == 0) begin
                        check("extra_beat", 32'(out_idx), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat_idx", 32'(out_idx), 32'(e.idx));
                        check("beat_data", out_data, e.data);
                        check("beat_last", 32'(out_last), 32'(e.last));
                        check("beat_chk", 32'(out_chk), 32'(e.chk));
                    end
                    if (seen == 1 && mode == 0) check("first_valid_cycle", n, 2);
                    // Already sampled: later writes must not show up in this dump.
                    if (out_idx != 0) rf[out_idx] = $urandom;
                    held = 0;
                    stall = 0;
                end else begin
                    held = 1; hd = out_data; hx = out_idx; hl = out_last; hc = out_chk;
                    stall++;
                end
            end
            if (done) begin
                fin = 1;
                check("err_flag", 32'(err), 32'(lo > hi));
                check("busy_at_done", 32'(busy), 0);
                if (mode == 0) check("done_cycle", n, 2 * nbeats + 1);
            end else if (n > 600) begin
                check("timeout", 0, 1);
                fin = 1;
            end
        end
        check("beats_left", exp_q.size(), 0);
        start = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        int lo, hi;
        rst_n = 1'b0; start = 1'b0; range_lo = '0; range_hi = '0; out_ready = 1'b0;
        for (int i = 0; i < 32; i++) rf[i] = 32'(i) * 32'h0101_0101;
        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;

        run_dump(0, 31, 0, -1, 0);
        rf[7] = 32'hDEAD_BEEF;
        run_dump(7, 7, 0, -1, 0);
        run_dump(10, 12, 1, -1, 0);
        run_dump(20, 3, 0, -1, 0);
        run_dump(0, 0, 0, -1, 0);
        rf[1] = 32'hF0F0_F0F0;
        rf[2] = 32'h0F0F_00FF;
        run_dump(1, 2, 0, -1, 0);
        run_dump(0, 10, 0, 4, 1);
        run_dump(28, 31, 2, -1, 0);

        for (int k = 0; k < 20; k++) begin
            for (int i = 1; i < 32; i++) rf[i] = $urandom;
            lo = $urandom_range(0, 31);
            hi = $urandom_range(0, 31);
            if ($urandom_range(0, 3) != 0 && lo > hi) begin
                int t = lo; lo = hi; hi = t;
            end
            run_dump(lo, hi, $urandom_range(0, 2), -1, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
